// File: rtl/acumulador_truncador_saturado_pkg.sv
// Shared constants and FSM encoding for the accumulate / rescale / saturate stage.
// Default word sizes match the upstream signed multiplier (ancho, dobleancho).
package acumulador_truncador_saturado_pkg;

    localparam int ANCHO_DEF      = 25;
    localparam int DOBLEANCHO_DEF = 2 * ANCHO_DEF;
    localparam int FRACCION_DEF   = 16;
    localparam int N_TERMINOS_DEF = 3;
    localparam int GUARDA_DEF     = 2;

    typedef enum logic {
        ACUM   = 1'b0,
        SALIDA = 1'b1
    } estado_t;

endpackage

// File: rtl/acumulador_truncador_saturado_saturador_truncador.sv
// Combinational rescale of the wide accumulated sum: arithmetic shift by FRAC, then clamp.
// Optional macro REDONDEO_EN adds half an LSB before the shift (round half toward +inf).
module saturador_truncador #(
    parameter int ENTRADA_W = 52,
    parameter int ANCHO     = 25,
    parameter int FRAC      = 16
) (
    input  logic signed [ENTRADA_W-1:0] suma,
    output logic signed [ANCHO-1:0]     resultado,
    output logic                        desborde
);

    // One extra bit so the rounding add can never wrap.
    localparam int EXT_W = ENTRADA_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-ANCHO+1){1'b0}}, {(ANCHO-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-ANCHO+1){1'b1}}, {(ANCHO-1){1'b0}}};
`ifdef REDONDEO_EN
    localparam logic signed [EXT_W-1:0] MEDIO = {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC - 1);
`endif

    logic signed [EXT_W-1:0] extendida;
    logic signed [EXT_W-1:0] desplazada;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        resultado  = '0;
        desborde   = 1'b0;
        extendida  = {suma[ENTRADA_W-1], suma};
`ifdef REDONDEO_EN
        extendida  = extendida + MEDIO;
`endif
        desplazada = extendida >>> FRAC;
        if (desplazada > MAX_V) begin
            resultado = MAX_V[ANCHO-1:0];
            desborde  = 1'b1;
        end else if (desplazada < MIN_V) begin
            resultado = MIN_V[ANCHO-1:0];
            desborde  = 1'b1;
        end else begin
            resultado = desplazada[ANCHO-1:0];
        end
    end

endmodule

// File: rtl/acumulador_truncador_saturado.sv
// Accumulates N_TERMINOS signed products per output sample, rescales and saturates the sum,
// and offers it downstream with a valid/taken handshake. Rounding option: REDONDEO_EN.
module acumulador_truncador_saturado
    import acumulador_truncador_saturado_pkg::*;
#(
    parameter int ANCHO      = ANCHO_DEF,
    parameter int FRAC       = FRACCION_DEF,
    parameter int N_TERMINOS = N_TERMINOS_DEF,
    parameter int GUARDA     = GUARDA_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [2*ANCHO-1:0] producto,
    input  logic                      producto_valido,
    output logic                      listo_entrada,
    output logic signed [ANCHO-1:0]   resultado,
    output logic                      resultado_valido,
    input  logic                      resultado_tomado,
    output logic                      desborde
);

    localparam int ACC_W = 2 * ANCHO + GUARDA;
    localparam int CNT_W = (N_TERMINOS > 1) ? $clog2(N_TERMINOS) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_TERMINOS - 1);

    estado_t                 estado, estado_sig;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] suma;
    logic [CNT_W-1:0]        cnt;
    logic                    transferencia;
    logic                    ultimo;
    logic signed [ANCHO-1:0] res_sat;
    logic                    desb_sat;

    assign listo_entrada    = (estado == ACUM);
    assign resultado_valido = (estado == SALIDA);
    assign transferencia    = producto_valido && listo_entrada;
    assign ultimo           = (cnt == ULTIMO);
    assign suma             = acc + ACC_W'(producto);

    saturador_truncador #(
        .ENTRADA_W (ACC_W),
        .ANCHO     (ANCHO),
        .FRAC      (FRAC)
    ) u_saturador (
        .suma      (suma),
        .resultado (res_sat),
        .desborde  (desb_sat)
    );

    always_comb begin
        estado_sig = estado;
        case (estado)
            ACUM:    if (transferencia && ultimo) estado_sig = SALIDA;
            SALIDA:  if (resultado_tomado)        estado_sig = ACUM;
            default: estado_sig = ACUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ACUM;
            acc       <= '0;
            cnt       <= '0;
            resultado <= '0;
            desborde  <= 1'b0;
        end else begin
            estado <= estado_sig;
            if (transferencia) begin
                if (ultimo) begin
                    acc       <= '0;
                    cnt       <= '0;
                    resultado <= res_sat;
                    desborde  <= desb_sat;
                end else begin
                    acc <= suma;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // resultado keeps its last value after the take; only the flag is per sample.
            if (resultado_valido && resultado_tomado) desborde <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acumulador_truncador_saturado.sv
// Self-checking bench: table of three-product frames with a result scoreboard, plus
// hand-written sequences for backpressure and reset in the middle of a frame / during output.
module tb_acumulador_truncador_saturado;

    localparam int ANCHO = 25;

`ifdef REDONDEO_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    localparam longint UNO     = 64'sd1 <<< 32;                      // 1.0 * 1.0
    localparam longint P_MAX   = 64'sd281474943156225;               // (2^24-1)^2
    localparam longint P_NEG   = -((64'sd1 <<< 48) - (64'sd1 <<< 24)); // -(2^24-1)*2^24
    localparam longint EXACTO  = (64'sd1 <<< 40) - (64'sd1 <<< 16);  // exactly +max after shift
    localparam longint DOS40   = 64'sd1 <<< 40;

    logic                      clk = 1'b0;
    logic                      reset;
    logic signed [2*ANCHO-1:0] producto;
    logic                      producto_valido;
    logic                      listo_entrada;
    logic signed [ANCHO-1:0]   resultado;
    logic                      resultado_valido;
    logic                      resultado_tomado;
    logic                      desborde;

    acumulador_truncador_saturado dut (
        .clk              (clk),
        .reset            (reset),
        .producto         (producto),
        .producto_valido  (producto_valido),
        .listo_entrada    (listo_entrada),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .resultado_tomado (resultado_tomado),
        .desborde         (desborde)
    );

    always #5 clk = ~clk;

    typedef struct {
        string  name;
        longint p0;
        longint p1;
        longint p2;
        longint exp_res;
        bit     exp_desb;
    } vec_t;

    typedef struct {
        string  name;
        longint res;
        bit     desb;
    } exp_t;

    exp_t esperados[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_product(input longint p);
        producto        = 50'(p);
        producto_valido = 1'b1;
        tick();
        producto_valido = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, " resultado"}, longint'(resultado), 0);
        check({name, " valido"}, longint'(resultado_valido), 0);
        check({name, " desborde"}, longint'(desborde), 0);
        check({name, " listo"}, longint'(listo_entrada), 1);
    endtask

    task automatic send_frame(input string name, input longint p0, input longint p1,
                              input longint p2, input longint er, input bit ed);
        exp_t e;
        e.name = name; e.res = er; e.desb = ed;
        esperados.push_back(e);
        check({name, " listo"}, longint'(listo_entrada), 1);
        send_product(p0);
        send_product(p1);
        check({name, " early valido"}, longint'(resultado_valido), 0);
        send_product(p2);
        check({name, " latency"}, longint'(resultado_valido), 1);
    endtask

    task automatic collect();
        exp_t e;
        int   k = 0;
        while (!resultado_valido && k < 10) begin
            tick();
            k++;
        end
        if (esperados.size() == 0) begin
            check("scoreboard empty", 0, 1);
        end else begin
            e = esperados.pop_front();
            if (!resultado_valido) begin
                check({e.name, " timeout"}, 0, 1);
            end else begin
                check({e.name, " resultado"}, longint'(resultado), e.res);
                check({e.name, " desborde"}, longint'(desborde), longint'(e.desb));
            end
        end
    endtask

    task automatic take(input string name);
        resultado_tomado = 1'b1;
        tick();
        resultado_tomado = 1'b0;
        check({name, " valido after take"}, longint'(resultado_valido), 0);
        check({name, " desborde after take"}, longint'(desborde), 0);
        check({name, " listo after take"}, longint'(listo_entrada), 1);
    endtask

    vec_t tabla[10];

    initial begin
        tabla[0] = '{"tres_uno",   UNO,    UNO,   UNO,   196608,    1'b0};
        tabla[1] = '{"tres_menos", -UNO,   -UNO,  -UNO,  -196608,   1'b0};
        tabla[2] = '{"sat_pos",    P_MAX,  P_MAX, P_MAX, 16777215,  1'b1};
        tabla[3] = '{"sat_neg",    P_NEG,  P_NEG, P_NEG, -16777216, 1'b1};
        tabla[4] = '{"menos_lsb",  -1,     0,     0,     RND ? 0 : -1, 1'b0};
        tabla[5] = '{"medio_lsb",  32768,  0,     0,     RND ? 1 : 0,  1'b0};
        tabla[6] = '{"max_exacto", EXACTO, 0,     0,     16777215,  1'b0};
        tabla[7] = '{"max_mas1",   DOS40,  0,     0,     16777215,  1'b1};
        tabla[8] = '{"min_exacto", -DOS40, 0,     0,     -16777216, 1'b0};
        tabla[9] = '{"mezcla",     UNO,    -(UNO >>> 1), 0, 32768,  1'b0};

        reset            = 1'b1;
        producto         = '0;
        producto_valido  = 1'b0;
        resultado_tomado = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");

        foreach (tabla[i]) begin
            send_frame(tabla[i].name, tabla[i].p0, tabla[i].p1, tabla[i].p2,
                       tabla[i].exp_res, tabla[i].exp_desb);
            collect();
            take(tabla[i].name);
        end

        // Backpressure: products offered while the result waits must be ignored.
        send_frame("backpressure", UNO, UNO, UNO, 196608, 1'b0);
        collect();
        for (int c = 0; c < 5; c++) begin
            producto        = 50'(UNO * 7);
            producto_valido = 1'b1;
            tick();
            check("bp resultado", longint'(resultado), 196608);
            check("bp desborde", longint'(desborde), 0);
            check("bp listo", longint'(listo_entrada), 0);
            check("bp valido", longint'(resultado_valido), 1);
        end
        take("bp");  // producto_valido still high: no bypass on the take cycle
        producto_valido = 1'b0;
        send_frame("tras_bp", UNO, UNO, 0, 131072, 1'b0);
        collect();
        take("tras_bp");

        // Reset after two of three products: the partial sum is discarded.
        send_product(UNO);
        send_product(UNO);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset valido", longint'(resultado_valido), 0);
        check("mid reset listo", longint'(listo_entrada), 1);
        check("mid reset resultado", longint'(resultado), 0);
        send_frame("tras_reset", UNO, UNO, UNO, 196608, 1'b0);
        collect();
        take("tras_reset");

        // Reset while a saturated result is pending.
        send_product(P_MAX);
        send_product(P_MAX);
        send_product(P_MAX);
        check("pend valido", longint'(resultado_valido), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("salida reset");
        send_frame("final", UNO * 2, 0, 0, 131072, 1'b0);
        collect();
        take("final");

        check("scoreboard drained", longint'(esperados.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
